fila_circular: RTL and testbench
================================

# fila_circular

Parametrised FIFO successor to the 8×8 queue. Replaces the shift-register storage with a circular buffer of configurable width and depth, read/write pointers, status flags and sticky error flags. Sits in the `clock_10khz` domain, on the consumer side of the deserialiser-to-queue path. Keeps the existing enqueue/dequeue semantics, including simultaneous-operation and pass-through, and adds flush, a valid strobe and error reporting.

## Interface
- `DATA_W`, 8, element width in bits (≥1)
- `DEPTH`, 8, capacity in elements (2..255; need not be a power of two)
- `ALMOST_FULL`, DEPTH-2, `almost_full_out` asserts when len ≥ this value (1..DEPTH)
- `LEN_W`, 8, width of `len_out`; must satisfy 2^LEN_W > DEPTH

- `clock_10khz` in 1: single clock, all logic on the rising edge
- `reset` in 1: synchronous, active-high
- `data_in` in DATA_W: element to enqueue
- `enqueue_in` in 1: enqueue request, sampled each edge
- `dequeue_in` in 1: dequeue request, sampled each edge
- `flush_in` in 1: synchronous discard of all contents
- `err_clr_in` in 1: clears the sticky error flags
- `data_out` out DATA_W: last dequeued element, registered
- `valid_out` out 1: one-cycle pulse, `data_out` updated this cycle
- `len_out` out LEN_W: current element count
- `empty_out`, `full_out`, `almost_full_out` out 1: status, decoded from the len register
- `overflow_out`, `underflow_out` out 1: sticky error flags

## Operation
- Storage: DEPTH×DATA_W array. Write pointer `wr_ptr` and read pointer `rd_ptr` each wrap from DEPTH-1 to 0 by explicit compare, not modulo-2^n.
- Priority each edge: `reset` > `flush_in` > enqueue/dequeue logic. `err_clr_in` is independent and takes effect in any cycle except reset.
- Enqueue only (len<DEPTH): write `data_in` at `wr_ptr`, advance `wr_ptr`, len+1.
- Enqueue only while full: element dropped. `overflow_out` set. No other state change.
- Dequeue only (len>0): `data_out` ← mem[`rd_ptr`], `valid_out`=1, advance `rd_ptr`, len−1.
- Dequeue only while empty: `data_out` holds its value, `valid_out`=0, `underflow_out` set.
- Both requests, 0<len≤DEPTH: read the head, write `data_in`, advance both pointers, len unchanged. Accepted when full; no overflow.
- Both requests, len=0: pass-through. `data_out` ← `data_in`, `valid_out`=1, pointers and len unchanged. No error flags.
- Flush: pointers←0, len←0, `valid_out`←0, `data_out` held. Requests in the same cycle are ignored and flag nothing.
- `err_clr_in` clears both sticky flags. If an error event occurs in the same cycle, set wins.
- Memory contents are not cleared on reset or flush; unread data is unreachable.

## Timing
- Reset values: `data_out`=0, `valid_out`=0, `len_out`=0, `empty_out`=1, `full_out`=0, `almost_full_out`=0 (1 if ALMOST_FULL=0 is ever allowed; it is not), `overflow_out`=0, `underflow_out`=0, pointers=0.
- Dequeue latency: request sampled at edge N. `data_out`/`valid_out` valid after edge N, i.e. during cycle N+1.
- Enqueue latency: `len_out` and flags update after the sampling edge. An element written at edge N is dequeueable at edge N+1.
- Status flags are combinational from the len register only; no input-to-output combinational path.
- Reset mid-operation: all state returns to reset values at that edge; queued data is lost.
- No handshake stall: requests are single-cycle, and the producer must check `full_out`/`empty_out` itself.

## Structure
- Package `fila_pkg`: default `DATA_W`/`DEPTH` constants, and an `op_e` enum (`OP_IDLE`, `OP_ENQ`, `OP_DEQ`, `OP_BOTH`, `OP_PASS`, `OP_FLUSH`) used to decode the per-cycle operation.
- Sub-module `fila_mem`: synchronous-write, synchronous-read DEPTH×DATA_W array with one write port and one read port. It is inferable as RAM; pointers and control stay in the top level.

## Test plan
- Reset, then enqueue 0x11..0x18 (DEPTH=8) → `len_out`=8, `full_out`=1, `almost_full_out` from len=6. Eight dequeues → `data_out` 0x11..0x18 in order, one `valid_out` pulse each.
- Full, enqueue 0xAA alone → `overflow_out`=1, len stays 8. Later dequeues never return 0xAA. `err_clr_in` → flag 0.
- Empty, dequeue alone → `underflow_out`=1, `data_out` unchanged, `valid_out`=0. Empty with enqueue+dequeue of 0x5C → `data_out`=0x5C next cycle, len 0, no flags.
- Wrap-around with DEPTH=5: 20 interleaved enqueue/dequeue and simultaneous ops against a reference model → order preserved, len correct at every cycle.
- Full with simultaneous enqueue 0x77 + dequeue → head is returned, len stays full, 0x77 emerges last. Flush with 3 elements → len 0, `empty_out`=1, `data_out` held.
- Assert `reset` during a burst of dequeues → all outputs at reset values on the next cycle, and subsequent enqueue of 0x42 then dequeue returns 0x42.

Source files
------------

// File: rtl/fila_pkg.sv
// Shared constants and per-cycle operation decode for the circular FIFO.
package fila_pkg;

    localparam int FILA_DATA_W = 8;
    localparam int FILA_DEPTH  = 8;

    // Operation selected for one clock edge, after priority resolution.
    typedef enum logic [2:0] {
        OP_IDLE  = 3'd0,
        OP_ENQ   = 3'd1,
        OP_DEQ   = 3'd2,
        OP_BOTH  = 3'd3,
        OP_PASS  = 3'd4,
        OP_FLUSH = 3'd5
    } op_e;

    // Flush dominates; a simultaneous enqueue+dequeue on an empty queue
    // becomes a pass-through of the incoming element.
    function automatic op_e decode_op(input logic flush, input logic enq,
                                      input logic deq, input logic empty);
        op_e op;
        op = OP_IDLE;
        if (flush)           op = OP_FLUSH;
        else if (enq && deq) op = empty ? OP_PASS : OP_BOTH;
        else if (enq)        op = OP_ENQ;
        else if (deq)        op = OP_DEQ;
        return op;
    endfunction

endpackage

// File: rtl/fila_circular_if.sv
// Request/status bundle between the producer/consumer and the FIFO.
interface fila_circular_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 8
);
    logic [DATA_W-1:0] data_in;
    logic              enqueue_in;
    logic              dequeue_in;
    logic              flush_in;
    logic              err_clr_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic [LEN_W-1:0]  len_out;
    logic              empty_out;
    logic              full_out;
    logic              almost_full_out;
    logic              overflow_out;
    logic              underflow_out;

    modport master (
        output data_in, enqueue_in, dequeue_in, flush_in, err_clr_in,
        input  data_out, valid_out, len_out, empty_out, full_out,
               almost_full_out, overflow_out, underflow_out
    );

    modport slave (
        input  data_in, enqueue_in, dequeue_in, flush_in, err_clr_in,
        output data_out, valid_out, len_out, empty_out, full_out,
               almost_full_out, overflow_out, underflow_out
    );
endinterface

// File: rtl/fila_mem.sv
// DEPTH x DATA_W storage, one synchronous write port and one synchronous
// read port; a read and write to the same address return the old contents.
module fila_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Write and registered read; the read register holds when not enabled.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/fila_circular.sv
// Circular-buffer FIFO with status flags, pass-through, flush and sticky
// overflow/underflow reporting.
module fila_circular
    import fila_pkg::*;
#(
    parameter int DATA_W      = FILA_DATA_W,
    parameter int DEPTH       = FILA_DEPTH,
    parameter int ALMOST_FULL = DEPTH - 2,
    parameter int LEN_W       = 8
) (
    input  logic     clock_10khz,
    input  logic     reset,
    fila_circular_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              byp_sel_q, byp_sel_d;
    logic [DATA_W-1:0] byp_data_q, byp_data_d;
    logic              we, re;
    logic [DATA_W-1:0] rdata;
    logic              empty, full;
    op_e               op;

    // Pointer advance with explicit wrap so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty = (len_q == '0);
    assign full  = (len_q == LEN_W'(DEPTH));
    assign op    = decode_op(bus.flush_in, bus.enqueue_in, bus.dequeue_in, empty);

    // Next-state decode of pointers, length, output source and error flags.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        len_d      = len_q;
        valid_d    = 1'b0;
        byp_sel_d  = byp_sel_q;
        byp_data_d = byp_data_q;
        we         = 1'b0;
        re         = 1'b0;
        ovf_d      = ovf_q & ~bus.err_clr_in;
        udf_d      = udf_q & ~bus.err_clr_in;
        case (op)
            OP_FLUSH: begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                len_d    = '0;
            end
            OP_ENQ: begin
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    we       = 1'b1;
                    wr_ptr_d = next_ptr(wr_ptr_q);
                    len_d    = len_q + LEN_W'(1);
                end
            end
            OP_DEQ: begin
                if (empty) begin
                    udf_d = 1'b1;
                end else begin
                    re        = 1'b1;
                    rd_ptr_d  = next_ptr(rd_ptr_q);
                    len_d     = len_q - LEN_W'(1);
                    valid_d   = 1'b1;
                    byp_sel_d = 1'b0;
                end
            end
            OP_BOTH: begin
                we        = 1'b1;
                re        = 1'b1;
                wr_ptr_d  = next_ptr(wr_ptr_q);
                rd_ptr_d  = next_ptr(rd_ptr_q);
                valid_d   = 1'b1;
                byp_sel_d = 1'b0;
            end
            OP_PASS: begin
                valid_d    = 1'b1;
                byp_sel_d  = 1'b1;
                byp_data_d = bus.data_in;
            end
            default: ;
        endcase
        if (reset) begin
            we = 1'b0;
            re = 1'b0;
        end
    end

    // State registers; reset routes data_out to a zeroed bypass register.
    always_ff @(posedge clock_10khz) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            len_q      <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            byp_sel_q  <= 1'b1;
            byp_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            len_q      <= len_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            byp_sel_q  <= byp_sel_d;
            byp_data_q <= byp_data_d;
        end
    end

    fila_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk_i   (clock_10khz),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.data_in),
        .re_i    (re),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign bus.data_out        = byp_sel_q ? byp_data_q : rdata;
    assign bus.valid_out       = valid_q;
    assign bus.len_out         = len_q;
    assign bus.empty_out       = empty;
    assign bus.full_out        = full;
    assign bus.almost_full_out = (len_q >= LEN_W'(ALMOST_FULL));
    assign bus.overflow_out    = ovf_q;
    assign bus.underflow_out   = udf_q;
endmodule

// File: tb/tb_fila_circular.sv
// Bench for fila_circular: a DEPTH=8 and a DEPTH=5 instance share stimulus;
// a queue-based model tracks whichever instance is selected.
module tb_fila_circular;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] t_din;
    logic       t_enq, t_deq, t_fl, t_clr;
    logic       sel5;

    fila_circular_if #(.DATA_W(8), .LEN_W(8)) if8 ();
    fila_circular_if #(.DATA_W(8), .LEN_W(8)) if5 ();

    assign if8.data_in = t_din;  assign if5.data_in = t_din;
    assign if8.enqueue_in = t_enq; assign if5.enqueue_in = t_enq;
    assign if8.dequeue_in = t_deq; assign if5.dequeue_in = t_deq;
    assign if8.flush_in = t_fl;  assign if5.flush_in = t_fl;
    assign if8.err_clr_in = t_clr; assign if5.err_clr_in = t_clr;

    fila_circular #(.DATA_W(8), .DEPTH(8), .ALMOST_FULL(6), .LEN_W(8)) dut8 (
        .clock_10khz(clk), .reset(rst), .bus(if8));
    fila_circular #(.DATA_W(8), .DEPTH(5), .ALMOST_FULL(3), .LEN_W(8)) dut5 (
        .clock_10khz(clk), .reset(rst), .bus(if5));

    logic [7:0] o_dout, o_len;
    logic       o_vld, o_emp, o_full, o_af, o_ov, o_un;
    always_comb begin
        o_dout = sel5 ? if5.data_out        : if8.data_out;
        o_len  = sel5 ? if5.len_out         : if8.len_out;
        o_vld  = sel5 ? if5.valid_out       : if8.valid_out;
        o_emp  = sel5 ? if5.empty_out       : if8.empty_out;
        o_full = sel5 ? if5.full_out        : if8.full_out;
        o_af   = sel5 ? if5.almost_full_out : if8.almost_full_out;
        o_ov   = sel5 ? if5.overflow_out    : if8.overflow_out;
        o_un   = sel5 ? if5.underflow_out   : if8.underflow_out;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model state
    logic [7:0] mq[$];
    logic [7:0] m_dout;
    logic       m_vld, m_ov, m_un, ovs, uns;
    int         m_depth, m_af;

    // Model update on each sampling edge, then compare shortly after it.
    always @(posedge clk) begin
        m_depth = sel5 ? 5 : 8;
        m_af    = sel5 ? 3 : 6;
        if (rst) begin
            mq.delete();
            m_dout = 8'h00; m_vld = 1'b0; m_ov = 1'b0; m_un = 1'b0;
        end else begin
            ovs = 1'b0; uns = 1'b0; m_vld = 1'b0;
            if (t_fl) begin
                mq.delete();
            end else if (t_enq && t_deq) begin
                if (mq.size() == 0) m_dout = t_din;
                else begin
                    m_dout = mq.pop_front();
                    mq.push_back(t_din);
                end
                m_vld = 1'b1;
            end else if (t_enq) begin
                if (mq.size() < m_depth) mq.push_back(t_din);
                else ovs = 1'b1;
            end else if (t_deq) begin
                if (mq.size() > 0) begin
                    m_dout = mq.pop_front();
                    m_vld = 1'b1;
                end else uns = 1'b1;
            end
            m_ov = (m_ov && !t_clr) || ovs;
            m_un = (m_un && !t_clr) || uns;
        end
        #1;
        chk("data_out", o_dout, m_dout);
        chk("valid_out", o_vld, m_vld);
        chk("len_out", o_len, mq.size());
        chk("empty_out", o_emp, mq.size() == 0);
        chk("full_out", o_full, mq.size() == m_depth);
        chk("almost_full_out", o_af, mq.size() >= m_af);
        chk("overflow_out", o_ov, m_ov);
        chk("underflow_out", o_un, m_un);
    end

    // Drive one cycle of inputs at the falling edge; return after the next one.
    task automatic step(input logic e, input logic d, input logic [7:0] x,
                        input logic f = 1'b0, input logic c = 1'b0, input logic r = 1'b0);
        t_enq = e; t_deq = d; t_din = x; t_fl = f; t_clr = c; rst = r;
        @(negedge clk);
    endtask

    task automatic rand_run(input int cycles);
        int bias;
        for (int i = 0; i < cycles; i++) begin
            bias = ((i / 16) % 2 == 0) ? 70 : 30;
            step($urandom_range(0, 99) < bias, $urandom_range(0, 99) < (100 - bias),
                 8'($urandom), $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5);
        end
    endtask

    initial begin
        rst = 1'b1; sel5 = 1'b0;
        t_din = 8'h00; t_enq = 1'b0; t_deq = 1'b0; t_fl = 1'b0; t_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset len", o_len, 0);
        chk("reset empty", o_emp, 1);
        chk("reset data", o_dout, 0);

        // Fill DEPTH=8
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 8'h11 + 8'(i));
            chk("fill almost_full", o_af, (i + 1) >= 6);
        end
        chk("fill len", o_len, 8);
        chk("fill full", o_full, 1);
        step(1, 0, 8'hAA);
        chk("overflow flag", o_ov, 1);
        chk("overflow len", o_len, 8);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 8'h00);
            chk("drain data", o_dout, 8'h11 + 8'(i));
            chk("drain valid", o_vld, 1);
        end
        step(0, 0, 8'h00);
        chk("idle valid", o_vld, 0);
        step(0, 0, 8'h00, 0, 1);
        chk("err clear", o_ov, 0);

        // Underflow and pass-through
        step(0, 1, 8'h00);
        chk("underflow flag", o_un, 1);
        chk("underflow data held", o_dout, 8'h18);
        chk("underflow valid", o_vld, 0);
        step(0, 0, 8'h00, 0, 1);
        step(1, 1, 8'h5C);
        chk("pass data", o_dout, 8'h5C);
        chk("pass valid", o_vld, 1);
        chk("pass len", o_len, 0);
        chk("pass flags", {o_ov, o_un}, 0);

        // Full with simultaneous ops
        for (int i = 0; i < 8; i++) step(1, 0, 8'h21 + 8'(i));
        step(1, 1, 8'h77);
        chk("both full head", o_dout, 8'h21);
        chk("both full len", o_len, 8);
        chk("both full no ovf", o_ov, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 8'h00);
        chk("tail element", o_dout, 8'h77);

        // Flush
        for (int i = 0; i < 3; i++) step(1, 0, 8'h61 + 8'(i));
        step(1, 1, 8'h00, 1);
        chk("flush len", o_len, 0);
        chk("flush empty", o_emp, 1);
        chk("flush data held", o_dout, 8'h77);

        rand_run(300);

        // Reset during a dequeue burst
        step(0, 0, 8'h00, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 8'h31 + 8'(i));
        step(0, 1, 8'h00);
        step(0, 1, 8'h00);
        step(0, 1, 8'h00, 0, 0, 1);
        chk("mid reset data", o_dout, 0);
        chk("mid reset len", o_len, 0);
        chk("mid reset valid", o_vld, 0);
        step(1, 0, 8'h42);
        step(0, 1, 8'h00);
        chk("post reset data", o_dout, 8'h42);
        chk("post reset valid", o_vld, 1);

        // DEPTH=5 instance: wrap-around
        sel5 = 1'b1;
        step(0, 0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 8'hB0 + 8'(i));
        chk("d5 full", o_full, 1);
        chk("d5 len", o_len, 5);
        for (int i = 0; i < 20; i++) begin
            case (i % 4)
                0: step(0, 1, 8'h00);
                1: step(1, 1, 8'hC0 + 8'(i));
                2: step(1, 0, 8'hC0 + 8'(i));
                default: step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom));
            endcase
        end
        rand_run(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
